// File: rtl/mul4_seq_ctrl.sv
// mul4_seq_ctrl: operand FIFO feeding a handshaked 4x4 multiplier, result held on a valid/ready port.
// Optional MUL_READY watchdog is built in when MUL4_SEQ_TIMEOUT_EN is defined.
module mul4_seq_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic       CK,
    input  logic       RN,
    input  logic       IN_VALID,
    output logic       IN_READY,
    input  logic [3:0] IN_A,
    input  logic [3:0] IN_B,
    output logic [3:0] MUL_A,
    output logic [3:0] MUL_B,
    output logic       MUL_START,
    input  logic       MUL_READY,
    input  logic [7:0] MUL_P,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic [7:0] OUT_P,
    output logic       OUT_ERR,
    output logic       BUSY
);
    localparam int unsigned OPD_W = 4;
    localparam int unsigned PRD_W = 8;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [OPD_W-1:0] a;
        logic [OPD_W-1:0] b;
    } opnd_t;

    typedef enum logic [2:0] {IDLE, LAUNCH, ARM, WAIT, DONE} state_t;

    state_t           state, state_next;
    opnd_t            mem [FIFO_DEPTH];
    opnd_t            head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_next;
    logic             full, empty, push, pop;
    logic             cap_load, out_load;
    logic [PRD_W-1:0] cap_val, cap_p;
    logic [OPD_W-1:0] mul_a, mul_b;
    logic             mul_start, busy;
    logic [PRD_W-1:0] out_p;
    logic             out_valid;

`ifdef MUL4_SEQ_TIMEOUT_EN
    localparam int unsigned WD_W = 8;
    logic [WD_W-1:0] wd;
    logic            wd_inc, cap_err_val, cap_err, out_err;
`endif

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign push     = IN_VALID & ~full;
    assign head     = mem[rd_ptr];
    assign IN_READY = ~full;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Payload storage has no reset; only the pointers define live entries.
    always_ff @(posedge CK) begin
        if (push) begin
            mem[wr_ptr] <= '{a: IN_A, b: IN_B};
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) state <= IDLE;
        else     state <= state_next;
    end

    // ARM exists only to let a READY left over from the previous job go by.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        cap_load   = 1'b0;
        cap_val    = MUL_P;
        out_load   = 1'b0;
`ifdef MUL4_SEQ_TIMEOUT_EN
        cap_err_val = 1'b0;
        wd_inc      = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: state_next = ARM;
            ARM:    state_next = WAIT;
            WAIT: begin
                if (MUL_READY) begin
                    cap_load   = 1'b1;
                    state_next = DONE;
                end
`ifdef MUL4_SEQ_TIMEOUT_EN
                else if (wd == WD_W'(TIMEOUT - 1)) begin
                    cap_load    = 1'b1;
                    cap_val     = '0;
                    cap_err_val = 1'b1;
                    state_next  = DONE;
                end else begin
                    wd_inc = 1'b1;
                end
`endif
            end
            DONE: begin
                if (!out_valid || OUT_READY) begin
                    out_load   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands, start pulse, capture and the held output slot.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            mul_a     <= '0;
            mul_b     <= '0;
            mul_start <= 1'b0;
            busy      <= 1'b0;
            cap_p     <= '0;
            out_p     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (pop) begin
                mul_a <= head.a;
                mul_b <= head.b;
            end
            mul_start <= (state_next == LAUNCH);
            busy      <= (count_next != '0) || (state_next != IDLE);
            if (cap_load) cap_p <= cap_val;
            if (out_load) begin
                out_p     <= cap_p;
                out_valid <= 1'b1;
            end else if (OUT_READY) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef MUL4_SEQ_TIMEOUT_EN
    // Watchdog restarts on every WAIT entry; the error bit travels with the product.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            wd      <= '0;
            cap_err <= 1'b0;
            out_err <= 1'b0;
        end else begin
            if (state == ARM)  wd <= '0;
            else if (wd_inc)   wd <= wd + WD_W'(1);
            if (cap_load)      cap_err <= cap_err_val;
            if (out_load)      out_err <= cap_err;
        end
    end

    assign OUT_ERR = out_err;
`else
    // TIMEOUT only sizes the watchdog, which this build leaves out.
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT;
    assign OUT_ERR        = 1'b0;
`endif

    assign MUL_A     = mul_a;
    assign MUL_B     = mul_b;
    assign MUL_START = mul_start;
    assign OUT_P     = out_p;
    assign OUT_VALID = out_valid;
    assign BUSY      = busy;

endmodule

// File: doc/mul4_seq_ctrl.md
MUL4_SEQ_CTRL -- requirements
Module: mul4_seq_ctrl

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving the operand FIFO entry count (power of two, 2..16).
REQ-002 The block SHALL have parameter TIMEOUT, default 15, giving the maximum wait cycles for MUL_READY (1..255).
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, with these ports:
- CK  in  1  clock, rising edge
- RN  in  1  asynchronous active-low reset
- IN_VALID  in  1  operand pair offered
- IN_READY  out  1  FIFO can accept
- IN_A  in  4  multiplicand
- IN_B  in  4  multiplier
- MUL_A  out  4  operand A to the multiplier
- MUL_B  out  4  operand B to the multiplier
- MUL_START  out  1  multiplier start pulse
- MUL_READY  in  1  multiplier done
- MUL_P  in  8  multiplier product
- OUT_VALID  out  1  result held
- OUT_READY  in  1  consumer accepts
- OUT_P  out  8  captured product
- OUT_ERR  out  1  result is a timeout (0 when the timeout feature is absent)
- BUSY  out  1  FIFO not empty or FSM not IDLE

Function
REQ-004 A push SHALL occur when IN_VALID and IN_READY are both 1 on a CK edge, storing {IN_A,IN_B} at the write pointer.
REQ-005 IN_READY SHALL equal NOT full, decoded from registers only.
- When full, a pop and an offered push in the same cycle SHALL NOT accept the push.
- When neither full nor empty, a simultaneous push and pop SHALL leave the count unchanged.
REQ-006 The read and write pointers SHALL wrap modulo FIFO_DEPTH, and the count SHALL range 0..FIFO_DEPTH.
REQ-007 The FSM SHALL have the states IDLE, LAUNCH, ARM, WAIT and DONE.
REQ-008 IDLE SHALL move to LAUNCH when the FIFO is not empty, popping the head into the MUL_A/MUL_B registers on the same edge.
REQ-009 In LAUNCH, MUL_START SHALL be 1 for exactly one cycle, and the FSM SHALL move to ARM.
REQ-010 ARM SHALL last one cycle with MUL_READY ignored, to discard a stale READY, and SHALL then move to WAIT.
REQ-011 In WAIT, a sampled MUL_READY=1 SHALL move the FSM to DONE, registering MUL_P into an internal capture register.
REQ-012 DONE SHALL transfer the capture register to OUT_P and set OUT_VALID when OUT_VALID=0, or when OUT_VALID=1 and OUT_READY=1, and SHALL then go to IDLE; otherwise it SHALL stall in DONE.
REQ-013 MUL_A and MUL_B SHALL hold stable from the LAUNCH edge until the FSM leaves WAIT.
REQ-014 OUT_VALID SHALL clear on OUT_READY=1 unless it is reloaded on the same edge, and OUT_P and OUT_ERR SHALL hold while OUT_VALID=1 and OUT_READY=0.
REQ-015 Launch-to-capture latency SHALL be 3 cycles plus the multiplier latency, and the minimum push-to-OUT_VALID latency SHALL be 5 cycles with an immediate MUL_READY.
REQ-016 The block SHALL sustain back-to-back jobs without bubbles beyond those the FSM imposes, and the product SHALL pass unmodified at 8 bits.

Reset
REQ-017 RN=0 SHALL asynchronously force:
- FSM to IDLE;
- pointers and count to 0;
- IN_READY=1;
- MUL_START, OUT_VALID and OUT_ERR to 0;
- MUL_A, MUL_B and OUT_P to 0;
- BUSY=0.
REQ-018 Reset asserted mid-job SHALL discard the FIFO contents and any in-flight result, with no MUL_START issued after release until a new push.
REQ-019 Reset release SHALL take effect on the first CK edge with RN=1.

Configuration
REQ-020 With macro MUL4_SEQ_TIMEOUT_EN defined, an 8-bit watchdog SHALL operate as follows:
- it counts WAIT cycles;
- at TIMEOUT cycles without MUL_READY, the FSM goes to DONE with the capture register set to 0x00 and an error flag set;
- the error flag is delivered as OUT_ERR=1 alongside that OUT_P;
- the watchdog clears on entering WAIT.
REQ-021 Without MUL4_SEQ_TIMEOUT_EN, no watchdog logic SHALL exist, WAIT SHALL wait indefinitely, and OUT_ERR SHALL be tied to 0.

Verification
REQ-022 The bench SHALL push A=0x3, B=0x5 and have the model raise MUL_READY 6 cycles after START -> OUT_P=0x0F, OUT_ERR=0, exactly one MUL_START pulse.
REQ-023 The bench SHALL push 5 pairs back-to-back with FIFO_DEPTH=4 and OUT_READY=0 -> IN_READY=0 after 4 accepted, 5th held until a pop.
REQ-024 The bench SHALL push 0xF*0xF and 0x0*0x9 with OUT_READY=1 -> OUT_P sequence 0xE1 then 0x00, in order.
REQ-025 The bench SHALL hold MUL_READY=1 continuously -> the ARM cycle ignores it, and capture occurs in the first WAIT cycle, not LAUNCH.
REQ-026 The bench SHALL assert RN=0 during WAIT with 2 entries queued -> all outputs at reset values immediately, and no START after release.
REQ-027 With MUL4_SEQ_TIMEOUT_EN and TIMEOUT=15, the bench SHALL never assert MUL_READY -> OUT_VALID=1, OUT_P=0x00, OUT_ERR=1 after 15 WAIT cycles, then the next job launches.
